// File: rtl/rr_arb_mux.sv
// N-channel arbitrating mux with one registered output stage.
// Grant comes from an external select, fixed priority or a round-robin pointer, chosen by MODE.
module rr_arb_mux #(
  parameter int XLEN = 32,
  parameter int NCH  = 4,
  parameter int MODE = 2,
  localparam int SELW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NCH*XLEN-1:0]   in_data,
  input  logic [NCH-1:0]        in_valid,
  output logic [NCH-1:0]        in_ready,
  input  logic [SELW-1:0]       sel,
  output logic [XLEN-1:0]       out_data,
  output logic [SELW-1:0]       out_ch,
  output logic                  out_valid,
  input  logic                  out_ready
);

  // Handshake: a word moves on a port when its valid and ready are both high at a
  // rising clk edge. in_ready may depend on out_ready; the outputs never do.

  logic            load_en;
  logic            grant_valid;
  logic            xfer;
  logic [SELW-1:0] grant;
  logic [SELW:0]   rr_sum;
  logic [SELW-1:0] rr_idx;

  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] out_data_q, out_data_d;
  logic [SELW-1:0] out_ch_q, out_ch_d;
  logic [SELW-1:0] ptr_q, ptr_d;

  assign load_en = !out_valid_q || out_ready;

  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    rr_sum      = '0;
    rr_idx      = '0;
    if (MODE == 0) begin
      if (int'(sel) < NCH) begin
        grant       = sel;
        grant_valid = in_valid[sel];
      end
    end else if (MODE == 1) begin
      for (int i = NCH - 1; i >= 0; i--) begin
        if (in_valid[i]) begin
          grant       = SELW'(i);
          grant_valid = 1'b1;
        end
      end
    end else begin
      // Walk the offsets downward so the nearest requester after ptr wins.
      for (int k = NCH - 1; k >= 0; k--) begin
        rr_sum = {1'b0, ptr_q} + (SELW + 1)'(k);
        if (rr_sum >= (SELW + 1)'(NCH)) rr_sum = rr_sum - (SELW + 1)'(NCH);
        rr_idx = rr_sum[SELW-1:0];
        if (in_valid[rr_idx]) begin
          grant       = rr_idx;
          grant_valid = 1'b1;
        end
      end
    end
  end

  // rst_n gates the transfer so nothing is accepted while reset is held.
  assign xfer = rst_n && load_en && grant_valid;

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < NCH; i++) begin
      in_ready[i] = xfer && (grant == SELW'(i));
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    ptr_d       = ptr_q;
    if (load_en) out_valid_d = grant_valid;
    if (xfer) begin
      out_data_d = in_data[int'(grant)*XLEN +: XLEN];
      out_ch_d   = grant;
      if (MODE == 2) ptr_d = (int'(grant) == NCH - 1) ? '0 : grant + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Bench for rr_arb_mux: one instance per MODE on shared inputs, a behavioural model
// checked every falling edge, plus directed scenarios with literal expectations.
module tb_rr_arb_mux;

  localparam int XLEN = 32;
  localparam int NCH  = 4;

  logic                clk;
  logic                rst_n;
  logic [NCH*XLEN-1:0] in_data;
  logic [NCH-1:0]      in_valid;
  logic [1:0]          sel;
  logic [2:0]          ordy;

  logic [NCH-1:0]  ir  [3];
  logic [XLEN-1:0] od  [3];
  logic [1:0]      och [3];
  logic            ov  [3];

  int checks;
  int failures;

  // Model state per mode
  logic            ev   [3];
  logic [XLEN-1:0] ed   [3];
  logic [1:0]      ech  [3];
  int              mptr [3];

  rr_arb_mux #(.XLEN(XLEN), .NCH(NCH), .MODE(0)) u_m0 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(ir[0]),
    .sel(sel), .out_data(od[0]), .out_ch(och[0]), .out_valid(ov[0]), .out_ready(ordy[0]));
  rr_arb_mux #(.XLEN(XLEN), .NCH(NCH), .MODE(1)) u_m1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(ir[1]),
    .sel(sel), .out_data(od[1]), .out_ch(och[1]), .out_valid(ov[1]), .out_ready(ordy[1]));
  rr_arb_mux #(.XLEN(XLEN), .NCH(NCH), .MODE(2)) u_m2 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(ir[2]),
    .sel(sel), .out_data(od[2]), .out_ch(och[2]), .out_valid(ov[2]), .out_ready(ordy[2]));

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int m, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s mode%0d t=%0t actual=%h required=%h", name, m, $time, act, exp);
    end
  endtask

  // Which channel the rules pick, or -1 when nobody qualifies.
  function automatic int model_grant(input int m, input int p, input logic [3:0] v, input logic [1:0] s);
    if (m == 0) return v[s] ? int'(s) : -1;
    if (m == 1) begin
      for (int i = 0; i < NCH; i++) if (v[i]) return i;
      return -1;
    end
    for (int k = 0; k < NCH; k++) if (v[(p + k) % NCH]) return (p + k) % NCH;
    return -1;
  endfunction

  // Compare process: check against the model, then advance it across the next rising edge.
  always @(negedge clk) begin
    for (int m = 0; m < 3; m++) begin
      logic       load;
      int         g;
      logic [3:0] exp_ir;
      exp_ir = '0;
      g      = -1;
      load   = 1'b0;
      if (!rst_n) begin
        ev[m] = 1'b0; ed[m] = '0; ech[m] = '0; mptr[m] = 0;
      end else begin
        load = !ev[m] || ordy[m];
        g    = model_grant(m, mptr[m], in_valid, sel);
        if (load && g >= 0) exp_ir[g] = 1'b1;
      end
      chk("out_valid", m, 32'(ov[m]), 32'(ev[m]));
      chk("out_data",  m, od[m], ed[m]);
      chk("out_ch",    m, 32'(och[m]), 32'(ech[m]));
      chk("in_ready",  m, 32'(ir[m]), 32'(exp_ir));
      if (rst_n && load) begin
        if (g >= 0) begin
          ev[m]  = 1'b1;
          ed[m]  = in_data[g*XLEN +: XLEN];
          ech[m] = 2'(g);
          if (m == 2) mptr[m] = (g + 1) % NCH;
        end else begin
          ev[m] = 1'b0;
        end
      end
    end
  end

  // Driver tasks
  task automatic set_a0_data();
    for (int i = 0; i < NCH; i++) in_data[i*XLEN +: XLEN] = 32'hA0 + 32'(i);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  logic [1:0] rr_seq [7];

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; in_valid = 4'b1111; sel = 2'd0; ordy = 3'b111;
    set_a0_data();
    rr_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Round-robin across four busy channels, one word per cycle with wrap.
    for (int k = 0; k < 7; k++) begin
      after_edge();
      chk("rr_seq_ch", 2, 32'(och[2]), 32'(rr_seq[k]));
      chk("rr_seq_valid", 2, 32'(ov[2]), 32'd1);
      chk("fixed_all_ch", 1, 32'(och[1]), 32'd0);
    end
    // Pointer now 3; only ch2 valid must be found by wrapping.
    in_valid = 4'b0100;
    #1 chk("rr_wrap_ready", 2, 32'(ir[2]), 32'b0100);
    after_edge();
    chk("rr_wrap_data", 2, od[2], 32'hA2);
    in_valid = 4'b1111;
    #1 chk("rr_ptr3_ready", 2, 32'(ir[2]), 32'b1000);

    // Fixed priority starves ch3.
    in_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      #1 chk("fixed_ready", 1, 32'(ir[1]), 32'b0010);
      after_edge();
      chk("fixed_ch", 1, 32'(och[1]), 32'd1);
    end

    // External select with a stall; sel change during the stall is ignored.
    sel = 2'd2; in_valid = 4'b0100; ordy[0] = 1'b1;
    after_edge();
    ordy[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      after_edge();
      chk("stall_valid", 0, 32'(ov[0]), 32'd1);
      chk("stall_data", 0, od[0], 32'hA2);
      chk("stall_ready", 0, 32'(ir[0]), 32'd0);
    end
    sel = 2'd1; in_valid = 4'b1111;
    after_edge();
    chk("stall_sel_data", 0, od[0], 32'hA2);
    chk("stall_sel_ch", 0, 32'(och[0]), 32'd2);
    ordy[0] = 1'b1;
    #1 chk("release_ready", 0, 32'(ir[0]), 32'b0010);
    after_edge();
    chk("release_ch", 0, 32'(och[0]), 32'd1);
    chk("release_data", 0, od[0], 32'hA1);

    // Selected channel idle: output drains.
    sel = 2'd2; in_valid = 4'b1011;
    #1 chk("idle_sel_ready", 0, 32'(ir[0]), 32'd0);
    after_edge();
    chk("idle_sel_valid", 0, 32'(ov[0]), 32'd0);

    // Asynchronous reset between edges with a pending word.
    in_valid = 4'b1111; ordy = 3'b000;
    after_edge();
    chk("pre_reset_valid", 2, 32'(ov[2]), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_valid", 2, 32'(ov[2]), 32'd0);
    chk("async_data", 2, od[2], 32'd0);
    chk("async_ch", 2, 32'(och[2]), 32'd0);
    chk("async_ready", 2, 32'(ir[2]), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1; in_valid = 4'b0110; ordy = 3'b111;
    after_edge();
    chk("post_reset_ch", 2, 32'(och[2]), 32'd1);
    chk("post_reset_data", 2, od[2], 32'hA1);

    // Randomized traffic checked by the model.
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NCH; i++) in_data[i*XLEN +: XLEN] = $urandom;
      in_valid = 4'($urandom_range(0, 15));
      sel      = 2'($urandom_range(0, 3));
      for (int m = 0; m < 3; m++) ordy[m] = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 199) == 0) begin
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
      end
    end

    @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
